// File: rtl/mem_pkg.sv
// Shared constants and types for the main-memory responder and the cache-fill FSMs.
package mem_pkg;

  localparam int unsigned BLOCK_WORDS     = 8;
  localparam int unsigned BLOCK_BYTES     = 16;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
  localparam int unsigned DEFAULT_LATENCY = 4;

  typedef enum logic {
    StIdle,
    StBurst
  } state_t;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] addr;
    logic [15:0] data;
  } resp_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// LATENCY-deep delay line for read responses; the last stage is the output register.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data,
  output logic        o_valid,
  output logic        o_last,
  output logic [15:0] o_addr,
  output logic [15:0] o_data
);

  resp_t r_stage [LATENCY];

  // Shift responses one stage per cycle; idle slots carry all-zero payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= {i_valid, i_valid & i_last,
                     i_valid ? i_addr : 16'h0000,
                     i_valid ? i_data : 16'h0000};
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[LATENCY-1].valid;
  assign o_last  = r_stage[LATENCY-1].last;
  assign o_addr  = r_stage[LATENCY-1].addr;
  assign o_data  = r_stage[LATENCY-1].data;

endmodule

// File: rtl/multicycle_mem_responder.sv
// Main memory behind the I/D-cache fill FSMs: single reads/writes and aligned block-read bursts,
// with read data returned after a fixed pipelined latency.
module multicycle_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY     = DEFAULT_LATENCY,
  parameter int unsigned DEPTH_WORDS = 32768,  // power of two, at most 32768
  parameter int unsigned BLOCK_WORDS = mem_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic        i_req_burst,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [15:0] o_resp_data,
  output logic [15:0] o_resp_addr,
  output logic        o_resp_last
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW    = $clog2(BLOCK_WORDS);
  localparam logic [15:0] BlkMask = ~(16'(BLOCK_WORDS * 2) - 16'd1);
  localparam logic [CntW-1:0] LastBeat = CntW'(BLOCK_WORDS - 1);

  state_t          r_state;
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_base;
  logic            r_ready;
  logic [15:0]     r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_wr_en;
  logic        w_iss_valid;
  logic        w_iss_last;
  logic [15:0] w_iss_addr;
  logic [15:0] w_iss_data;
  logic        w_unused_addr_lsb;

  assign w_accept          = i_req_valid & r_ready;
  assign w_wr_en           = w_accept & i_req_wr;
  assign w_unused_addr_lsb = i_req_addr[0];
  assign o_req_ready       = r_ready;

  // Pick the word issued this cycle: a burst beat takes priority, otherwise an accepted read.
  always_comb begin
    w_iss_valid = 1'b0;
    w_iss_last  = 1'b0;
    w_iss_addr  = 16'h0000;
    if (r_state == StBurst) begin
      w_iss_valid = 1'b1;
      // Base is block-aligned, so OR-ing the beat offset never carries out of the block.
      w_iss_addr  = r_base | 16'({r_cnt, 1'b0});
      w_iss_last  = (r_cnt == LastBeat);
    end else if (w_accept && !i_req_wr) begin
      w_iss_valid = 1'b1;
      if (i_req_burst) begin
        w_iss_addr = i_req_addr & BlkMask;
        w_iss_last = 1'b0;
      end else begin
        w_iss_addr = {i_req_addr[15:1], 1'b0};
        w_iss_last = 1'b1;
      end
    end
  end

  // Array is sampled in the issue cycle.
  assign w_iss_data = r_mem[w_iss_addr[AW:1]];

  // Word array: written at the end of the accept cycle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[i_req_addr[AW:1]] <= i_req_wdata;
    end
  end

  // Request FSM with registered ready; a write with req_burst set is handled as a single write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_base  <= 16'h0000;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept && i_req_burst && !i_req_wr) begin
            r_state <= StBurst;
            r_cnt   <= CntW'(1);
            r_base  <= i_req_addr & BlkMask;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        StBurst: begin
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastBeat) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_iss_valid),
    .i_last  (w_iss_last),
    .i_addr  (w_iss_addr),
    .i_data  (w_iss_data),
    .o_valid (o_resp_valid),
    .o_last  (o_resp_last),
    .o_addr  (o_resp_addr),
    .o_data  (o_resp_data)
  );

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Self-checking bench for multicycle_mem_responder: reference model plus response scoreboard.
module tb_multicycle_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [15:0] resp_addr;
  logic        resp_last;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem_model [int];
  int          cyc = 0;
  int          ready_from = 1 << 30;
  int          checks = 0;
  int          errors = 0;
  bit          acc_seen = 0;
  int          acc_cyc = 0;
  int          burst_cyc = 0;

  multicycle_mem_responder #(
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_wr     (req_wr),
    .i_req_burst  (req_burst),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_data  (resp_data),
    .o_resp_addr  (resp_addr),
    .o_resp_last  (resp_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    int idx = int'(a[15:1]);
    return mem_model.exists(idx) ? mem_model[idx] : 16'h0000;
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_data", {16'd0, resp_data}, 32'd0);
      chk("rst_addr", {16'd0, resp_addr}, 32'd0);
      chk("rst_last", {31'd0, resp_last}, 32'd0);
      sb.delete();
      ready_from = cyc + 2;
      acc_seen   = 1'b0;
    end else begin
      bit m_ready;
      m_ready = (cyc >= ready_from);
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      acc_seen = m_ready && req_valid;
      if (acc_seen) begin
        acc_cyc = cyc;
        if (req_wr) begin
          mem_model[int'(req_addr[15:1])] = req_wdata;
        end else if (req_burst) begin
          logic [15:0] base;
          base = req_addr & 16'hFFF0;
          for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            a = base + 16'(2 * i);
            sb.push_back('{addr: a, data: model_rd(a), last: (i == 7), cyc: cyc + i + LAT});
          end
          ready_from = cyc + 8;
          burst_cyc  = cyc;
        end else begin
          logic [15:0] a;
          a = {req_addr[15:1], 1'b0};
          sb.push_back('{addr: a, data: model_rd(a), last: 1'b1, cyc: cyc + LAT});
        end
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_addr", {16'd0, resp_addr}, {16'd0, e.addr});
        chk("resp_data", {16'd0, resp_data}, {16'd0, e.data});
        chk("resp_last", {31'd0, resp_last}, {31'd0, e.last});
      end else begin
        chk("resp_idle", {31'd0, resp_valid}, 32'd0);
      end
    end
  end

  // Called #1 after a rising edge; holds the request until accepted, returns #1 after that edge.
  task automatic send(input logic wr, input logic burst, input logic [15:0] addr,
                      input logic [15:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_seen && n < 40);
    #1;
    req_valid = 1'b0;
    if (!acc_seen) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read the next cycle.
    send(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    send(1'b0, 1'b0, 16'h0010, 16'h0000);
    idle(LAT + 2);

    // Preload a block and a few low words.
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 16'h0020 + 16'(2 * i), 16'h1000 + 16'(i));
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 16'(2 * i), 16'hA000 + 16'(i));

    // Unaligned burst, with a read held against it.
    send(1'b0, 1'b1, 16'h0026, 16'h0000);
    send(1'b0, 1'b0, 16'h0004, 16'h0000);
    chk("held_accept_cyc", 32'(acc_cyc - burst_cyc), 32'd8);
    idle(LAT + 4);

    // Back-to-back singles; odd address drops bit 0.
    send(1'b0, 1'b0, 16'h0000, 16'h0000);
    send(1'b0, 1'b0, 16'h0002, 16'h0000);
    send(1'b0, 1'b0, 16'h0004, 16'h0000);
    send(1'b0, 1'b0, 16'h0007, 16'h0000);
    idle(LAT + 2);

    // Write with burst flag is a single write.
    send(1'b1, 1'b1, 16'h0040, 16'h5A5A);
    send(1'b0, 1'b0, 16'h0040, 16'h0000);
    idle(LAT + 2);

    // Burst in the top block must not wrap.
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 16'hFFF0 + 16'(2 * i), 16'hC0DE ^ 16'(i));
    send(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    idle(LAT + 10);

    // Reset in the middle of a burst.
    send(1'b1, 1'b0, 16'h0100, 16'h1234);
    send(1'b0, 1'b1, 16'h0020, 16'h0000);
    idle(2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(LAT + 4);
    send(1'b0, 1'b0, 16'h0100, 16'h0000);
    send(1'b0, 1'b1, 16'h002A, 16'h0000);
    idle(LAT + 12);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
